// File: rtl/serial_negate_rx.sv
// rtl/serial_negate_rx.sv - LSB-first serial receiver with optional on-the-fly two's-complement negation
module serial_negate_rx #(
    parameter int WIDTH  = 8,
    parameter bit NEGATE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             neg_ovf,
    output logic             overrun,
    output logic             frame_err
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic             q;
    logic [WIDTH-1:0] sr;

    logic             accept;
    logic             q_term;
    logic             obit;
    logic             complete;
    logic             buf_load;
    logic             bad_frame;
    logic [CW-1:0]    pos;
    logic [WIDTH-1:0] full_word;

    // sof always restarts at bit 0 with a clean borrow, even in the middle of a word
    always_comb begin
        accept    = bit_valid & (sof | (state == SHIFT));
        bad_frame = bit_valid & (sof ? (state == SHIFT) : (state == IDLE));
        q_term    = sof ? 1'b0 : q;
        obit      = NEGATE ? (bit_in ^ q_term) : bit_in;
        pos       = sof ? '0 : cnt;
        complete  = accept & (pos == CW'(WIDTH - 1));
        full_word = sr;
        full_word[pos] = obit;
        buf_load  = complete & (~word_valid | word_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            q          <= 1'b0;
            sr         <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            neg_ovf    <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            frame_err <= bad_frame;

            if (accept) begin
                sr[pos] <= obit;
                q       <= NEGATE ? (q_term | bit_in) : 1'b0;
                if (complete) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    state <= SHIFT;
                    cnt   <= pos + 1'b1;
                end
            end

            // Only the most-negative input has no borrow before a set MSB
            if (buf_load) begin
                word_out   <= full_word;
                neg_ovf    <= NEGATE & ~q_term & bit_in;
                word_valid <= 1'b1;
            end else if (complete) begin
                overrun <= 1'b1;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end

endmodule
